// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch sequencer: default widths, reset PC
// and the sequencer state encodings.
package instr_fetch_ctrl_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch bus: instruction-memory read port plus the valid/ready handoff to decode.
// The master side is the fetch sequencer.
interface instr_fetch_ctrl_if #(
  parameter int XLEN = instr_fetch_ctrl_pkg::XLEN_DEF
);

  logic            imem_rd_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  modport master (
    output imem_rd_en, imem_addr, if_valid, if_pc, if_instr,
    input  imem_rdata, if_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, if_valid, if_pc, if_instr,
    output imem_rdata, if_ready
  );

endinterface

// File: rtl/instr_fetch_ctrl_buf.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; flush clears it and
// takes priority over push.
module instr_fetch_ctrl_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  input  logic                             flush,
  output logic [WIDTH-1:0]                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle-latency instruction memory: owns the fetch PC,
// buffers returned words with their PCs and redirects on taken branches.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int              BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                misalign_err,
  instr_fetch_ctrl_if.master  bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [1:0]        state_reg, state_next;
  logic [XLEN-1:0]   fetch_pc_reg, tag_pc_reg;
  logic [XLEN-1:0]   last_pc_reg, last_instr_reg;
  logic              inflight_reg, misalign_reg;
  logic [CNT_W-1:0]  count;
  logic [2*XLEN-1:0] head_data;
  logic [XLEN-1:0]   head_pc, head_instr;
  logic              if_valid, pop, push, issue;

  assign head_pc    = head_data[2*XLEN-1:XLEN];
  assign head_instr = head_data[XLEN-1:0];
  assign if_valid   = (count != '0);
  assign pop        = if_valid & bus.if_ready;
  // A response landing in a redirect cycle belongs to the abandoned path.
  assign push       = inflight_reg & !redirect_valid;

  // Only issue when the eventual response is guaranteed a free slot.
  assign issue = !rst && fetch_en && !redirect_valid &&
                 ((OCC_W'(count) + OCC_W'(inflight_reg)) <
                  (OCC_W'(BUF_DEPTH) + OCC_W'(pop)));

  instr_fetch_ctrl_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({tag_pc_reg, bus.imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_data),
    .count     (count)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET: state_next = ST_RUN;
      ST_RUN:   if (redirect_valid) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_RUN;
      default:  state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_RESET;
      fetch_pc_reg   <= RESET_PC;
      tag_pc_reg     <= '0;
      inflight_reg   <= 1'b0;
      misalign_reg   <= 1'b0;
      last_pc_reg    <= '0;
      last_instr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      misalign_reg <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid)
        fetch_pc_reg <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (issue)
        fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
      if (issue) tag_pc_reg <= fetch_pc_reg;
      // Remember the last head shown so outputs hold while the buffer is empty.
      if (if_valid) begin
        last_pc_reg    <= head_pc;
        last_instr_reg <= head_instr;
      end
    end
  end

  assign bus.imem_rd_en = issue;
  assign bus.imem_addr  = fetch_pc_reg;
  assign bus.if_valid   = if_valid;
  assign bus.if_pc      = if_valid ? head_pc : last_pc_reg;
  assign bus.if_instr   = if_valid ? head_instr : last_instr_reg;
  assign misalign_err   = misalign_reg;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized bench for instr_fetch_ctrl against a queue-based reference of the
// fetch pipeline; memory returns {16'hC0DE, addr[15:0]} one cycle after a read.
module tb_instr_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_ready = 1'b0;
  logic        misalign_err;
  logic [31:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_ctrl_if #(.XLEN(32)) bus ();

  instr_fetch_ctrl #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err),
    .bus            (bus)
  );

  assign bus.imem_rdata = mem_rdata;
  assign bus.if_ready   = if_ready;

  always #5 clk = ~clk;

  // Instruction memory: data only meaningful the cycle after a read strobe.
  always @(posedge clk) begin
    if (bus.imem_rd_en) mem_rdata <= {16'hC0DE, bus.imem_addr[15:0]};
    else                mem_rdata <= $urandom;
  end

  // Reference state: fetch PC, PCs in flight, PCs buffered, last head shown.
  logic [31:0] m_buf[$];
  logic [31:0] m_pend[$];
  logic [31:0] m_fetch_pc, m_last_pc, m_last_instr;
  bit          m_mis  = 1'b0;
  bit          m_init = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic fe, input logic rdy,
                      input logic rv, input logic [31:0] rpc);
    bit          exp_valid, exp_pop, exp_rd;
    logic [31:0] exp_pc, exp_instr, head;
    int          occ;
    @(negedge clk);
    rst = r; fetch_en = fe; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    exp_valid = (m_buf.size() != 0);
    head      = exp_valid ? m_buf[0] : 32'h0;
    exp_pc    = exp_valid ? head : m_last_pc;
    exp_instr = exp_valid ? instr_of(head) : m_last_instr;
    exp_pop   = exp_valid && rdy;
    occ       = m_buf.size() + m_pend.size() - (exp_pop ? 1 : 0);
    exp_rd    = !r && fe && !rv && (occ < DEPTH);

    if (m_init) begin
      check("imem_rd_en", {31'b0, bus.imem_rd_en}, {31'b0, exp_rd});
      if (exp_rd) check("imem_addr", bus.imem_addr, m_fetch_pc);
      check("if_valid", {31'b0, bus.if_valid}, {31'b0, exp_valid});
      check("if_pc", bus.if_pc, exp_pc);
      check("if_instr", bus.if_instr, exp_instr);
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    end else if (r) begin
      check("imem_rd_en_rst", {31'b0, bus.imem_rd_en}, 32'h0);
    end

    if (r) begin
      m_buf.delete(); m_pend.delete();
      m_fetch_pc = 32'h0; m_last_pc = 32'h0; m_last_instr = 32'h0;
      m_mis = 1'b0; m_init = 1'b1;
    end else begin
      if (exp_valid) begin
        m_last_pc = head; m_last_instr = instr_of(head);
      end
      if (exp_pop) void'(m_buf.pop_front());
      if (rv) begin
        m_buf.delete(); m_pend.delete();
        m_fetch_pc = {rpc[31:2], 2'b00};
        m_mis = (rpc[1:0] != 2'b00);
      end else begin
        m_mis = 1'b0;
        if (m_pend.size() != 0) m_buf.push_back(m_pend.pop_front());
        if (exp_rd) begin
          m_pend.push_back(m_fetch_pc);
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic run(input int n, input logic fe, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, fe, rdy, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] rpc;
    // Reset, then streaming fetch with decode always ready.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    run(4, 1'b1, 1'b1);
    // Decode stall: head must hold, issue stops when full.
    run(5, 1'b1, 1'b0);
    run(5, 1'b1, 1'b1);
    // Redirect with a full buffer.
    run(3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
    run(6, 1'b1, 1'b1);
    // Misaligned redirect target.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0046);
    run(5, 1'b1, 1'b1);
    // Reset with buffered and in-flight data.
    run(1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    run(5, 1'b1, 1'b1);
    // Address wrap.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    run(6, 1'b1, 1'b1);
    // Fetch disabled: in-flight completes, redirect still taken.
    run(3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0101);
    run(3, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);
    // Back-to-back redirects: the last one wins.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0302);
    run(5, 1'b1, 1'b1);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: rpc = $urandom & 32'h0000_0FFF;
      endcase
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 11) == 0),
           rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
